// File: rtl/counter_ctrl_pkg.sv
// Shared state encoding and sizing helper for the counter command controller.
package counter_ctrl_pkg;

  localparam logic [1:0] StateIdleEnc   = 2'd0;
  localparam logic [1:0] StateAutoEnc   = 2'd1;
  localparam logic [1:0] StateAlarmEnc  = 2'd2;
  localparam logic [1:0] StateReloadEnc = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = StateIdleEnc,
    StAuto   = StateAutoEnc,
    StAlarm  = StateAlarmEnc,
    StReload = StateReloadEnc
  } state_t;

  // Counter width for a terminal count of v-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, debouncer and rising-edge pulse.
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CntMax) begin
        level_q <= sync2_q;
        pulse_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Command generator for the up/down threshold counter: manual buttons or timed auto stepping.
module counter_cmd_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 50_000_000,
  parameter int unsigned ALARM_CYCLES    = 100_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_load,
  input  logic         sw_auto,
  input  logic         threshold,
  input  logic [N-1:0] count_in,
  output logic         enable,
  output logic         dec,
  output logic         load,
  output logic         alarm,
  output logic [1:0]   state_out
);

  localparam int unsigned TW = cnt_w(TICK_CYCLES);
  localparam int unsigned AW = cnt_w(ALARM_CYCLES);
  localparam logic [TW-1:0] TickMax  = TW'(TICK_CYCLES - 1);
  localparam logic [AW-1:0] AlarmMax = AW'(ALARM_CYCLES - 1);

  logic up_p, down_p, load_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clock  (clock),
    .reset  (reset),
    .btn_i  (btn_up),
    .pulse_o(up_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clock  (clock),
    .reset  (reset),
    .btn_i  (btn_down),
    .pulse_o(down_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clock  (clock),
    .reset  (reset),
    .btn_i  (btn_load),
    .pulse_o(load_p)
  );

  state_t        state_q;
  logic          auto_s1_q, auto_s2_q;
  logic          enable_q, dec_q, load_q, alarm_q;
  logic          skip_q;
  logic [TW-1:0] tick_q;
  logic [AW-1:0] alarm_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      auto_s1_q   <= 1'b0;
      auto_s2_q   <= 1'b0;
      enable_q    <= 1'b0;
      dec_q       <= 1'b0;
      load_q      <= 1'b0;
      alarm_q     <= 1'b0;
      skip_q      <= 1'b0;
      tick_q      <= '0;
      alarm_cnt_q <= '0;
    end else begin
      auto_s1_q <= sw_auto;
      auto_s2_q <= auto_s1_q;
      enable_q  <= 1'b0;
      dec_q     <= 1'b0;
      load_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (auto_s2_q) begin
            state_q <= StAuto;
            tick_q  <= '0;
            skip_q  <= 1'b0;
          end else if (load_p) begin
            load_q <= 1'b1;
          end else if (up_p ^ down_p) begin
            enable_q <= 1'b1;
            dec_q    <= down_p;
          end
        end
        StAuto: begin
          skip_q <= 1'b0;
          // Threshold wins over leaving auto mode so an alarm is never lost.
          if (threshold && !skip_q) begin
            state_q     <= StAlarm;
            alarm_q     <= 1'b1;
            alarm_cnt_q <= '0;
            tick_q      <= '0;
          end else if (!auto_s2_q) begin
            state_q <= StIdle;
            tick_q  <= '0;
          end else if (tick_q >= TickMax) begin
            tick_q   <= '0;
            enable_q <= 1'b1;
            // Stepping from all-ones wraps the counter; treat it like a threshold hit.
            if (&count_in) begin
              state_q     <= StAlarm;
              alarm_q     <= 1'b1;
              alarm_cnt_q <= '0;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        StAlarm: begin
          if (alarm_cnt_q >= AlarmMax) begin
            state_q <= StReload;
            alarm_q <= 1'b0;
            load_q  <= 1'b1;
          end else begin
            alarm_cnt_q <= alarm_cnt_q + AW'(1);
          end
        end
        StReload: begin
          tick_q  <= '0;
          // The counter's threshold may still reflect the pre-load value for one cycle.
          skip_q  <= auto_s2_q;
          state_q <= auto_s2_q ? StAuto : StIdle;
        end
      endcase
    end
  end

  assign enable    = enable_q;
  assign dec       = dec_q;
  assign load      = load_q;
  assign alarm     = alarm_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Bench for counter_cmd_ctrl driving a behavioural threshold counter (reset 7, ref 9).
module tb_counter_cmd_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned TK = 8;
  localparam int unsigned AL = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0, sw_auto = 1'b0;
  logic         threshold;
  logic [N-1:0] count_in;
  logic         enable, dec, load, alarm;
  logic [1:0]   state_out;

  logic [N-1:0] cnt_q;
  logic [N-1:0] ref_v = 4'd9;
  logic         preset = 1'b0;
  logic [N-1:0] preset_val = '0;

  int checks = 0, failures = 0;
  int en_pulses = 0, ld_pulses = 0, inv_viol = 0;

  counter_cmd_ctrl #(
    .N              (N),
    .DEBOUNCE_CYCLES(DB),
    .TICK_CYCLES    (TK),
    .ALARM_CYCLES   (AL)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .sw_auto  (sw_auto),
    .threshold(threshold),
    .count_in (count_in),
    .enable   (enable),
    .dec      (dec),
    .load     (load),
    .alarm    (alarm),
    .state_out(state_out)
  );

  always #5 clock = ~clock;

  // The counter being commanded.
  always @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 4'd7;
    else if (preset) cnt_q <= preset_val;
    else if (load) cnt_q <= ref_v;
    else if (enable) cnt_q <= dec ? cnt_q - 4'd1 : cnt_q + 4'd1;
  end
  assign threshold = (cnt_q > ref_v);
  assign count_in  = cnt_q;

  always @(negedge clock) begin
    if (enable) en_pulses <= en_pulses + 1;
    if (load) ld_pulses <= ld_pulses + 1;
    if ((enable && load) || (dec && !enable)) inv_viol <= inv_viol + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_preset(input logic [N-1:0] v);
    @(negedge clock);
    preset = 1'b1;
    preset_val = v;
    @(negedge clock);
    preset = 1'b0;
  endtask

  task automatic wait_for(input int which, input int budget, output int n, output bit ok);
    logic hit;
    n = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clock);
      n++;
      case (which)
        0:       hit = enable;
        1:       hit = alarm;
        default: hit = load;
      endcase
      if (hit) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct packed {
    logic u, d, l;
    logic e_en, e_dec, e_ld;
  } vec_t;

  vec_t vecs [8];
  int   exp_cnt;

  // Command the buttons {u,d,l} would produce, applied to a count.
  function automatic int apply_cmd(input int c, input logic u, input logic d, input logic l);
    if (l) return int'(ref_v);
    if (u && !d) return (c + 1) % 16;
    if (d && !u) return (c + 15) % 16;
    return c;
  endfunction

  initial begin
    int  e0, l0, n, hold, rel;
    bit  ok;
    logic [2:0] r;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_enable", enable, 0);
    check("rst_dec", dec, 0);
    check("rst_load", load, 0);
    check("rst_alarm", alarm, 0);
    check("rst_state", state_out, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    exp_cnt = 7;

    // Table: single and simultaneous buttons, 20-cycle holds, pulse at edge 7
    for (int i = 0; i < 8; i++) begin
      e0 = en_pulses;
      l0 = ld_pulses;
      @(negedge clock);
      btn_up = vecs[i].u;
      btn_down = vecs[i].d;
      btn_load = vecs[i].l;
      repeat (6) @(posedge clock);
      #1;
      check($sformatf("vec%0d_early", i), {enable, load}, 0);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_enable", i), enable, vecs[i].e_en);
      check($sformatf("vec%0d_dec", i), dec, vecs[i].e_dec);
      check($sformatf("vec%0d_load", i), load, vecs[i].e_ld);
      exp_cnt = apply_cmd(exp_cnt, vecs[i].u, vecs[i].d, vecs[i].l);
      repeat (13) @(posedge clock);
      @(negedge clock);
      btn_up = 1'b0;
      btn_down = 1'b0;
      btn_load = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      check($sformatf("vec%0d_en_pulses", i), en_pulses - e0, vecs[i].e_en);
      check($sformatf("vec%0d_ld_pulses", i), ld_pulses - l0, vecs[i].e_ld);
      check($sformatf("vec%0d_count", i), cnt_q, exp_cnt);
    end

    // Bouncing down button
    do_preset(4'd7);
    repeat (2) @(posedge clock);
    #1;
    e0 = en_pulses;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      btn_down = ((k / 2) % 2 == 0);
    end
    @(negedge clock);
    btn_down = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("bounce_early", enable, 0);
    @(posedge clock);
    #1;
    check("bounce_enable", enable, 1);
    check("bounce_dec", dec, 1);
    repeat (6) @(posedge clock);
    @(negedge clock);
    btn_down = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("bounce_pulses", en_pulses - e0, 1);
    check("bounce_count", cnt_q, 6);
    exp_cnt = 6;

    // Random clean button combinations against the command model
    for (int i = 0; i < 16; i++) begin
      r = 3'($urandom_range(0, 7));
      hold = $urandom_range(8, 14);
      rel = $urandom_range(8, 12);
      e0 = en_pulses;
      l0 = ld_pulses;
      @(negedge clock);
      btn_up = r[0];
      btn_down = r[1];
      btn_load = r[2];
      repeat (hold) @(posedge clock);
      @(negedge clock);
      btn_up = 1'b0;
      btn_down = 1'b0;
      btn_load = 1'b0;
      repeat (rel) @(posedge clock);
      #1;
      exp_cnt = apply_cmd(exp_cnt, r[0], r[1], r[2]);
      check($sformatf("rnd%0d_count", i), cnt_q, exp_cnt);
      check($sformatf("rnd%0d_en_pulses", i), en_pulses - e0, (!r[2] && (r[0] ^ r[1])) ? 1 : 0);
      check($sformatf("rnd%0d_ld_pulses", i), ld_pulses - l0, r[2] ? 1 : 0);
    end

    // Auto run: ticks 7->8->9->10, threshold alarm, reload to 9
    do_preset(4'd7);
    @(negedge clock);
    sw_auto = 1'b1;
    wait_for(0, 20, n, ok);
    check("auto_first_tick_seen", ok, 1);
    check("auto_tick0_count", cnt_q, 7);
    for (int i = 1; i < 3; i++) begin
      wait_for(0, 12, n, ok);
      check($sformatf("auto_tick%0d_period", i), n, TK);
      check($sformatf("auto_tick%0d_count", i), cnt_q, 7 + i);
    end
    wait_for(1, 6, n, ok);
    check("auto_alarm_seen", ok, 1);
    check("auto_alarm_count", cnt_q, 10);
    check("auto_alarm_state", state_out, 2);
    n = 1;
    while (n < 20) begin
      @(negedge clock);
      if (!alarm) break;
      n++;
    end
    check("auto_alarm_len", n, AL);
    check("reload_load", load, 1);
    check("reload_state", state_out, 3);
    @(negedge clock);
    check("reload_load_done", load, 0);
    check("reload_back_auto", state_out, 1);
    check("reload_count", cnt_q, 9);
    sw_auto = 1'b0;
    repeat (6) @(negedge clock);
    check("auto_off_idle", state_out, 0);

    // Wrap guard: tick from 15 alarms even though threshold never rises
    ref_v = 4'd15;
    do_preset(4'd14);
    @(negedge clock);
    sw_auto = 1'b1;
    wait_for(0, 20, n, ok);
    check("wrap_tick_seen", ok, 1);
    check("wrap_tick0_count", cnt_q, 14);
    wait_for(0, 12, n, ok);
    check("wrap_tick1_period", n, TK);
    check("wrap_tick1_count", cnt_q, 15);
    check("wrap_alarm", alarm, 1);
    check("wrap_state", state_out, 2);
    @(negedge clock);
    check("wrap_count_zero", cnt_q, 0);

    // Reset on the third alarm cycle
    @(negedge clock);
    check("midalarm_alarm_before", alarm, 1);
    #2;
    reset = 1'b1;
    #1;
    check("midalarm_alarm", alarm, 0);
    check("midalarm_state", state_out, 0);
    check("midalarm_enable_load", {enable, load}, 0);
    sw_auto = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    l0 = ld_pulses;
    repeat (15) @(posedge clock);
    #1;
    check("post_reset_no_load", ld_pulses - l0, 0);
    check("post_reset_alarm", alarm, 0);
    check("post_reset_state", state_out, 0);

    check("invariants", inv_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_cmd_ctrl.md
Name: counter_cmd_ctrl

Overview:
Command generator that drives the control inputs (enable, dec, load) of the N-bit up/down threshold counter and consumes its threshold/count outputs. Converts raw board pushbuttons into single-cycle counter commands in manual mode. In auto mode it steps the counter up on a timer, raises an alarm when the counter's threshold rises or the count wraps, then reloads the counter.

Parameters:
N, 4, counter width; must match the driven counter.
DEBOUNCE_CYCLES, 1_000_000, number of consecutive stable synchronized cycles needed to accept a button level.
TICK_CYCLES, 50_000_000, clock cycles between auto-mode increment commands.
ALARM_CYCLES, 100_000_000, clock cycles for which alarm is held high.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_up  input  1  raw pushbutton: increment command
btn_down  input  1  raw pushbutton: decrement command
btn_load  input  1  raw pushbutton: load command
sw_auto  input  1  raw switch: 1 selects auto mode
threshold  input  1  threshold output of the counter (count > ref)
count_in  input  N  current counter value
enable  output  1  counter enable, one-cycle pulse
dec  output  1  direction qualifier for enable (1 = decrement)
load  output  1  counter load, one-cycle pulse
alarm  output  1  high while in ALARM
state_out  output  2  current FSM state encoding

Behaviour:
- Reset (async, active-high): state IDLE; enable, dec, load, alarm = 0; state_out = 0; all synchronizers, debounced levels and timers = 0.
- All outputs are registered. enable and load are never high in the same cycle. dec = 0 whenever enable = 0.
- Each button: 2-FF synchronizer, then debouncer. The debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count. A rising edge of the debounced level produces one internal pulse.
- Latency: a command pulse appears on the outputs exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the raw button high, provided the button stays stable. A button held through reset release yields exactly one pulse.
- sw_auto: 2-FF synchronizer only, no debounce.
- States: IDLE=0, AUTO=1, ALARM=2, RELOAD=3.
- IDLE:
  - up pulse → enable=1, dec=0 for 1 cycle.
  - down pulse → enable=1, dec=1 for 1 cycle.
  - load pulse → load=1 for 1 cycle.
  - Pulses arriving in the same cycle: load has priority; up and down together (without load) → no command.
  - Synchronized sw_auto=1 → AUTO; any button pulse in that same cycle is dropped.
- AUTO:
  - Button pulses are ignored.
  - Tick counter runs 0..TICK_CYCLES-1. At the terminal count it issues enable=1, dec=0 for 1 cycle and returns to 0.
  - threshold is sampled every cycle. threshold=1 → ALARM on the next edge, including when it is already high on entry.
  - Wrap guard: a tick issued while count_in = all-ones → ALARM after that tick.
  - sw_auto=0 → IDLE on the next edge; the tick counter clears.
- ALARM:
  - alarm=1 for exactly ALARM_CYCLES cycles, then → RELOAD.
  - sw_auto changes are ignored until exit.
- RELOAD:
  - load=1 for 1 cycle, so the counter takes its reference value and threshold becomes 0.
  - Then → AUTO if sw_auto=1, else → IDLE.
  - The tick counter restarts at 0.
- The first cycle of AUTO does not evaluate threshold that is left stale from before RELOAD; evaluation begins on the second cycle.
- Reset mid-operation: all outputs drop asynchronously, including an alarm in progress; no partial pulse remains.
- Timer widths are $clog2 of their parameter; the counters saturate rather than wrap.

Decomposition:
- Package counter_ctrl_pkg: state_t enum (IDLE, AUTO, ALARM, RELOAD, 2-bit) and the localparam encodings used for state_out.
- Sub-module btn_debounce #(DEBOUNCE_CYCLES): synchronizer, debounce counter and rising-edge pulse. It is instantiated three times (up, down, load).
- The FSM, tick timer, alarm timer and output registers live in the top module.

Test Plan:
(Bench parameters: N=4, DEBOUNCE_CYCLES=4, TICK_CYCLES=8, ALARM_CYCLES=5; a model counter with reset value 7 and ref=9.)
- Manual up: btn_up high 20 cycles → a single enable=1, dec=0 pulse at edge 7 after press; count 7→8; no second pulse until release and re-press.
- Bounce: btn_down toggles every 2 cycles for 12 cycles, then stays high → exactly one enable, dec=1 pulse, 7 cycles after the final rising edge; count 7→6.
- Simultaneous buttons: btn_up and btn_load raised on the same edge → only load=1; count=9. btn_up and btn_down together → no command.
- Auto run: sw_auto=1 from count 7 → enable pulses every 8 cycles; count 8, 9, 10. threshold rises at 10 → alarm high for 5 cycles → load pulse → count 9 → back in AUTO with state_out=1.
- Wrap guard: ref=15, count=14, auto → ticks to 15, then the tick from 15 (wraps to 0) → ALARM, alarm=1.
- Reset mid-ALARM: assert reset on the 3rd alarm cycle → alarm=0 and state_out=0 immediately, asynchronously; no load pulse after reset release.
